// File: rtl/logic_sweep_checker_pkg.sv
// Shared types and widths for the 4-input logic sweep checker.
// Contents: sweep state enum, vector/counter/timer widths.
package logic_sweep_pkg;

   localparam int unsigned VEC_W   = 4;
   localparam int unsigned NUM_VEC = 16;
   localparam int unsigned CNT_W   = 5;
   localparam int unsigned TMR_W   = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_e;

endpackage

// File: rtl/logic_sweep_checker_if.sv
// Stimulus/capture bundle between the sweep checker and the networks under test.
// master: stimulus side (drives start, returns fn_a/fn_b, observes results)
// slave : checker side (receives start/fn_*, drives vec and all results)
interface logic_sweep_checker_if;
   import logic_sweep_pkg::*;

   logic             start;
   logic [VEC_W-1:0] vec;
   logic             fn_a;
   logic             fn_b;
   logic             busy;
   logic             done;
   logic             pass;
   logic [CNT_W-1:0] mism_cnt;
   logic             fail_a;
   logic             fail_b;
   logic [VEC_W-1:0] first_fail_idx;
   logic             first_fail_vld;
   logic [CNT_W-1:0] xchk_cnt;

   modport master (
      output start, fn_a, fn_b,
      input  vec, busy, done, pass, mism_cnt, fail_a, fail_b,
             first_fail_idx, first_fail_vld, xchk_cnt
   );

   modport slave (
      input  start, fn_a, fn_b,
      output vec, busy, done, pass, mism_cnt, fail_a, fail_b,
             first_fail_idx, first_fail_vld, xchk_cnt
   );

endinterface

// File: rtl/logic_sweep_checker_settle_timer.sv
// Settle-time down counter: load has priority, decrement saturates at zero.
// Ports: clk, rst_n, load_i, dec_i, load_val_i[W], zero_c_o (combinational zero flag)
module sweep_settle_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load_i,
   input  logic         dec_i,
   input  logic [W-1:0] load_val_i,
   output logic         zero_c_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // next count
   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_c_o = (count_q == '0);

endmodule

// File: rtl/logic_sweep_checker.sv
// Self-checking synchronous sweep of all 16 {a,b,c,d} vectors over two networks.
// Ports: clk, rst_n (async active-low), sif (logic_sweep_checker_if.slave:
//   start/fn_a/fn_b in; vec/busy/done/pass/mism_cnt/fail_a/fail_b/
//   first_fail_idx/first_fail_vld/xchk_cnt out).
// Build option: define DIFF_CHECK_EN to count fn_a!=fn_b samples in xchk_cnt;
//   otherwise xchk_cnt is tied to 0.
module logic_sweep_checker
   import logic_sweep_pkg::*;
#(
   parameter logic [15:0] EXP_TT_A   = 16'h0000,
   parameter logic [15:0] EXP_TT_B   = 16'h0000,
   parameter int unsigned SETTLE_CYC = 2
) (
   input logic                  clk,
   input logic                  rst_n,
   logic_sweep_checker_if.slave sif
);

   state_e           state_q;
   logic [VEC_W-1:0] vec_q;
   logic [VEC_W-1:0] first_fail_idx_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic             fail_a_q;
   logic             fail_b_q;
   logic             first_fail_vld_q;
   logic [CNT_W-1:0] mism_cnt_q;
   logic [CNT_W-1:0] xchk_cnt_q;

   logic accept_c;
   logic sample_c;
   logic last_vec_c;
   logic err_a_c;
   logic err_b_c;
   logic mism_c;
   logic tmr_load_c;
   logic tmr_dec_c;
   logic tmr_zero_c;

   // strobes and per-vector comparison
   always_comb begin
      accept_c   = ((state_q == IDLE) || (state_q == DONE)) && sif.start;
      sample_c   = (state_q == SAMPLE);
      last_vec_c = (vec_q == VEC_W'(NUM_VEC - 1));
      err_a_c    = sif.fn_a ^ EXP_TT_A[vec_q];
      err_b_c    = sif.fn_b ^ EXP_TT_B[vec_q];
      mism_c     = err_a_c | err_b_c;
      // reload on accept and on every non-final sample
      tmr_load_c = accept_c | (sample_c & ~last_vec_c);
      tmr_dec_c  = (state_q == SETTLE) & ~tmr_zero_c;
   end

   sweep_settle_timer #(
      .W (TMR_W)
   ) u_settle_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load_i     (tmr_load_c),
      .dec_i      (tmr_dec_c),
      .load_val_i (TMR_W'(SETTLE_CYC)),
      .zero_c_o   (tmr_zero_c)
   );

   // sweep FSM and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q          <= IDLE;
         vec_q            <= '0;
         busy_q           <= 1'b0;
         done_q           <= 1'b0;
         pass_q           <= 1'b0;
         fail_a_q         <= 1'b0;
         fail_b_q         <= 1'b0;
         first_fail_idx_q <= '0;
         first_fail_vld_q <= 1'b0;
         mism_cnt_q       <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (sif.start) begin
                  vec_q            <= '0;
                  busy_q           <= 1'b1;
                  done_q           <= 1'b0;
                  pass_q           <= 1'b0;
                  fail_a_q         <= 1'b0;
                  fail_b_q         <= 1'b0;
                  first_fail_idx_q <= '0;
                  first_fail_vld_q <= 1'b0;
                  mism_cnt_q       <= '0;
                  state_q          <= SETTLE;
               end
            end
            SETTLE: begin
               if (tmr_zero_c) begin
                  state_q <= SAMPLE;
               end
            end
            SAMPLE: begin
               if (mism_c) begin
                  mism_cnt_q <= mism_cnt_q + CNT_W'(1);
                  if (!first_fail_vld_q) begin
                     first_fail_idx_q <= vec_q;
                     first_fail_vld_q <= 1'b1;
                  end
               end
               fail_a_q <= fail_a_q | err_a_c;
               fail_b_q <= fail_b_q | err_b_c;
               if (last_vec_c) begin
                  // pass reflects the count including this final sample
                  vec_q   <= '0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (mism_cnt_q == '0) && !mism_c;
                  state_q <= DONE;
               end else begin
                  vec_q   <= vec_q + VEC_W'(1);
                  state_q <= SETTLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef DIFF_CHECK_EN
   // cross-compare of the two networks, independent of the expected tables
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         xchk_cnt_q <= '0;
      end else if (accept_c) begin
         xchk_cnt_q <= '0;
      end else if (sample_c && (sif.fn_a != sif.fn_b)) begin
         xchk_cnt_q <= xchk_cnt_q + CNT_W'(1);
      end
   end
`else
   assign xchk_cnt_q = '0;
`endif

   assign sif.vec            = vec_q;
   assign sif.busy           = busy_q;
   assign sif.done           = done_q;
   assign sif.pass           = pass_q;
   assign sif.mism_cnt       = mism_cnt_q;
   assign sif.fail_a         = fail_a_q;
   assign sif.fail_b         = fail_b_q;
   assign sif.first_fail_idx = first_fail_idx_q;
   assign sif.first_fail_vld = first_fail_vld_q;
   assign sif.xchk_cnt       = xchk_cnt_q;

endmodule

// File: tb/tb_logic_sweep_checker.sv
// Scoreboard bench for logic_sweep_checker: networks are modelled as truth
// tables indexed by vec; expected sweep results come from table arithmetic.
// Honours DIFF_CHECK_EN for the expected xchk_cnt.
module tb_logic_sweep_checker;
   import logic_sweep_pkg::*;

   localparam logic [15:0] EXP_A     = 16'hB3E9;
   localparam logic [15:0] EXP_B     = 16'h5AC7;
   localparam int unsigned SETTLE    = 2;
   localparam int          SWEEP_CYC = 16 * (SETTLE + 2);

   typedef struct {
      int mism;
      int fa;
      int fb;
      int idx;
      int vld;
      int pass;
      int xchk;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] tt_a;
   logic [15:0] tt_b;
   int          checks = 0;
   int          errors = 0;
   bit          stim_done = 1'b0;
   exp_t        sb_q[$];

   always #5 clk = ~clk;

   logic_sweep_checker_if sif ();

   assign sif.fn_a = tt_a[sif.vec];
   assign sif.fn_b = tt_b[sif.vec];

   logic_sweep_checker #(
      .EXP_TT_A   (EXP_A),
      .EXP_TT_B   (EXP_B),
      .SETTLE_CYC (SETTLE)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sif   (sif)
   );

   function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
      exp_t        e;
      logic [15:0] ea;
      logic [15:0] eb;
      logic [15:0] m;
      ea     = a ^ EXP_A;
      eb     = b ^ EXP_B;
      m      = ea | eb;
      e.mism = $countones(m);
      e.fa   = (ea != 16'h0) ? 1 : 0;
      e.fb   = (eb != 16'h0) ? 1 : 0;
      e.pass = (m == 16'h0) ? 1 : 0;
      e.vld  = (m != 16'h0) ? 1 : 0;
      e.idx  = 0;
      for (int i = 15; i >= 0; i--) begin
         if (m[i]) e.idx = i;
      end
`ifdef DIFF_CHECK_EN
      e.xchk = $countones(a ^ b);
`else
      e.xchk = 0;
`endif
      return e;
   endfunction

   task automatic chk(input string nm, input int act, input int exp_v);
      checks++;
      if (act != exp_v) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp_v, $time);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_vec"},      int'(sif.vec), 0);
      chk({tag, "_busy"},     int'(sif.busy), 0);
      chk({tag, "_done"},     int'(sif.done), 0);
      chk({tag, "_pass"},     int'(sif.pass), 0);
      chk({tag, "_mism"},     int'(sif.mism_cnt), 0);
      chk({tag, "_fail_a"},   int'(sif.fail_a), 0);
      chk({tag, "_fail_b"},   int'(sif.fail_b), 0);
      chk({tag, "_ff_idx"},   int'(sif.first_fail_idx), 0);
      chk({tag, "_ff_vld"},   int'(sif.first_fail_vld), 0);
      chk({tag, "_xchk"},     int'(sif.xchk_cnt), 0);
   endtask

   // pops one expectation per rising done and checks results and latency
   task automatic monitor();
      int   cyc = 0;
      int   start_cyc = 0;
      bit   pb = 1'b0;
      bit   pd = 1'b0;
      exp_t e;
      while (!stim_done) begin
         @(negedge clk);
         cyc++;
         if (!rst_n) begin
            pb = 1'b0;
            pd = 1'b0;
         end else begin
            if (sif.busy && !pb) start_cyc = cyc;
            if (sif.done && !pd) begin
               if (sb_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL sb_unexpected_done actual=done expected=no_done @%0t", $time);
               end else begin
                  e = sb_q.pop_front();
                  chk("latency",        cyc - start_cyc, SWEEP_CYC);
                  chk("busy_at_done",   int'(sif.busy), 0);
                  chk("vec_at_done",    int'(sif.vec), 0);
                  chk("mism_cnt",       int'(sif.mism_cnt), e.mism);
                  chk("pass",           int'(sif.pass), e.pass);
                  chk("fail_a",         int'(sif.fail_a), e.fa);
                  chk("fail_b",         int'(sif.fail_b), e.fb);
                  chk("first_fail_vld", int'(sif.first_fail_vld), e.vld);
                  chk("first_fail_idx", int'(sif.first_fail_idx), e.idx);
                  chk("xchk_cnt",       int'(sif.xchk_cnt), e.xchk);
               end
            end
            pb = sif.busy;
            pd = sif.done;
         end
      end
   endtask

   task automatic run_sweep(input logic [15:0] a, input logic [15:0] b, input bit restarts);
      int k;
      tt_a = a;
      tt_b = b;
      sb_q.push_back(model(a, b));
      @(negedge clk);
      sif.start = 1'b1;
      @(negedge clk);
      sif.start = 1'b0;
      k = 1;
      while (!sif.done && (k < SWEEP_CYC + 40)) begin
         sif.start = restarts && ((k == 10) || (k == 30));
         @(negedge clk);
         k++;
      end
      sif.start = 1'b0;
      if (!sif.done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout actual=no_done expected=done_within_%0d @%0t",
                  SWEEP_CYC + 40, $time);
         void'(sb_q.pop_back());
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic stimulus();
      logic [15:0] ra;
      logic [15:0] rb;
      sif.start = 1'b0;
      tt_a      = 16'h0;
      tt_b      = 16'h0;
      rst_n     = 1'b1;
      #3 rst_n  = 1'b0;
      #1 check_reset("rst_init");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      run_sweep(EXP_A, EXP_B, 1'b0);                               // clean pass
      run_sweep(~EXP_A, EXP_B, 1'b0);                              // every fn_a wrong
      run_sweep(EXP_A ^ 16'h0200, EXP_B, 1'b0);                    // single miss at vec 9
      run_sweep(EXP_A, EXP_B ^ 16'h1008, 1'b0);                    // fn_b misses at 3 and 12
      run_sweep(EXP_A ^ 16'h8000, EXP_B, 1'b0);                    // miss only on last vector
      run_sweep(EXP_A, ~EXP_A, 1'b1);                              // ignored restarts, fn_b=~fn_a

      // asynchronous reset in the middle of a sweep
      tt_a = ~EXP_A;
      tt_b = ~EXP_B;
      @(negedge clk);
      sif.start = 1'b1;
      @(negedge clk);
      sif.start = 1'b0;
      repeat (20) @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check_reset("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      run_sweep(EXP_A ^ 16'h0011, EXP_B ^ 16'h0100, 1'b0);

      for (int n = 0; n < 6; n++) begin
         if (n < 3) begin
            ra = EXP_A ^ 16'($urandom() & $urandom() & $urandom());
            rb = EXP_B ^ 16'($urandom() & $urandom() & $urandom());
         end else begin
            ra = 16'($urandom());
            rb = 16'($urandom());
         end
         run_sweep(ra, rb, 1'($urandom_range(0, 1)));
      end

      repeat (4) @(negedge clk);
      chk("sb_empty", sb_q.size(), 0);
      stim_done = 1'b1;
   endtask

   initial begin
      fork
         monitor();
         stimulus();
      join
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
